// File: rtl/inst_pkg.sv
// Shared types and default constants for the instruction fetch stage.
// Optional feature macro used by this slice: INST_FETCH_PC_TAG_EN.
package inst_pkg;

   localparam int unsigned INST_IW          = 32;
   localparam int unsigned INST_AW          = 11;
   localparam int unsigned INST_FETCH_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/inst_ram.sv
// Instruction RAM: one write port, one synchronous read port (1-cycle latency).
// Optional feature macro used by this slice: INST_FETCH_PC_TAG_EN (not used here).
module inst_ram
   import inst_pkg::*;
#(
   parameter int unsigned IW = INST_IW,
   parameter int unsigned AW = INST_AW
) (
   input  logic          clk,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic          ren,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   localparam int unsigned WORDS = 1 << AW;

   logic [IW-1:0] mem [WORDS];

   // Write port and registered read port; contents are not reset.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
      if (ren) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: streams RAM words [start_pc, end_pc] through a
// prefetch FIFO to a valid/ready master port, once or looping.
// Optional feature macro: INST_FETCH_PC_TAG_EN adds instf_m_pc and stores the
// word address alongside each FIFO entry.
module inst_fetch_unit
   import inst_pkg::*;
#(
   parameter int unsigned IW         = INST_IW,
   parameter int unsigned AW         = INST_AW,
   parameter int unsigned FIFO_DEPTH = INST_FETCH_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instw_wen,
   input  logic [AW-1:0] instw_addr,
   input  logic [IW-1:0] instw_data,
   input  logic          start,
   input  logic [AW-1:0] start_pc,
   input  logic [AW-1:0] end_pc,
   input  logic          loop_en,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [IW-1:0] instf_m_data,
   output logic          instf_m_valid,
   input  logic          instf_m_ready
`ifdef INST_FETCH_PC_TAG_EN
   ,
   output logic [AW-1:0] instf_m_pc
`endif
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
`ifdef INST_FETCH_PC_TAG_EN
   localparam int unsigned EW = IW + AW;
`else
   localparam int unsigned EW = IW;
`endif

   fetch_state_e  state_q;
   logic [AW-1:0] pc_q, start_pc_q, end_pc_q;
   logic          loop_q, done_q, inflight_q;
   logic [IW-1:0] ram_rdata;
   logic          ren, ram_wen, push, pop;
   logic [CW:0]   credit_used;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic [EW-1:0] push_entry, head;

   assign busy          = (state_q != IDLE);
   assign done          = done_q;
   assign ram_wen       = instw_wen && (state_q == IDLE);
   // Occupied FIFO slots plus the read still in the RAM pipeline.
   assign credit_used   = (CW+1)'(count_q) + (CW+1)'(inflight_q);
   assign ren           = (state_q == FETCH) && !abort &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
   assign push          = inflight_q && !abort;
   assign instf_m_valid = (count_q != '0);
   assign pop           = instf_m_valid && instf_m_ready;
   assign head          = fifo_mem[rd_ptr_q];
   assign instf_m_data  = instf_m_valid ? head[IW-1:0] : '0;

`ifdef INST_FETCH_PC_TAG_EN
   logic [AW-1:0] rd_pc_q;
   assign push_entry = {rd_pc_q, ram_rdata};
   assign instf_m_pc = instf_m_valid ? head[EW-1:IW] : '0;

   // Remember the address of the read in flight so it travels with its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pc_q <= '0;
      end else if (ren) begin
         rd_pc_q <= pc_q;
      end
   end
`else
   assign push_entry = ram_rdata;
`endif

   inst_ram #(
      .IW (IW),
      .AW (AW)
   ) u_ram (
      .clk   (clk),
      .wen   (ram_wen),
      .waddr (instw_addr),
      .wdata (instw_data),
      .ren   (ren),
      .raddr (pc_q),
      .rdata (ram_rdata)
   );

   // Control FSM: run bookkeeping, PC sequencing and the registered done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         start_pc_q <= '0;
         end_pc_q   <= '0;
         loop_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !abort) begin
                  start_pc_q <= start_pc;
                  end_pc_q   <= end_pc;
                  loop_q     <= loop_en;
                  pc_q       <= start_pc;
                  state_q    <= FETCH;
               end
            end
            FETCH: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (ren) begin
                  if (pc_q == end_pc_q) begin
                     if (loop_q) begin
                        pc_q <= start_pc_q;
                     end else begin
                        state_q <= DRAIN;
                     end
                  end else begin
                     pc_q <= pc_q + AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if ((count_q == '0) && !inflight_q) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // One-deep read pipeline tracker; abort discards the pending read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= ren;
      end
   end

   // FIFO pointers and occupancy; abort flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (abort) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; outputs are masked while empty so no reset is needed here.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= push_entry;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit.
// Honours INST_FETCH_PC_TAG_EN when the design is built with it.
module tb_inst_fetch_unit;
   import inst_pkg::*;

   localparam int unsigned IW = 32;
   localparam int unsigned AW = 11;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instw_wen = 1'b0;
   logic [AW-1:0] instw_addr = '0;
   logic [IW-1:0] instw_data = '0;
   logic          start = 1'b0;
   logic [AW-1:0] start_pc = '0;
   logic [AW-1:0] end_pc = '0;
   logic          loop_en = 1'b0;
   logic          abort = 1'b0;
   logic          busy, done, instf_m_valid;
   logic [IW-1:0] instf_m_data;
   logic          instf_m_ready = 1'b0;
`ifdef INST_FETCH_PC_TAG_EN
   logic [AW-1:0] instf_m_pc;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt, first_cyc, last_cyc, ntx;

   logic [IW-1:0] got_q[$];
   logic [IW-1:0] exp_q[$];
   logic [AW-1:0] gotpc_q[$];
   logic [AW-1:0] exppc_q[$];

   always #5 clk = ~clk;

   inst_fetch_unit #(
      .IW         (IW),
      .AW         (AW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instw_wen     (instw_wen),
      .instw_addr    (instw_addr),
      .instw_data    (instw_data),
      .start         (start),
      .start_pc      (start_pc),
      .end_pc        (end_pc),
      .loop_en       (loop_en),
      .abort         (abort),
      .busy          (busy),
      .done          (done),
      .instf_m_data  (instf_m_data),
      .instf_m_valid (instf_m_valid),
      .instf_m_ready (instf_m_ready)
`ifdef INST_FETCH_PC_TAG_EN
      ,
      .instf_m_pc    (instf_m_pc)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ram_write(input logic [AW-1:0] a, input logic [IW-1:0] d);
      instw_wen  = 1'b1;
      instw_addr = a;
      instw_data = d;
      tick();
      instw_wen  = 1'b0;
   endtask

   // Pulse start for one edge; returns in cycle T+1.
   task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic l);
      start    = 1'b1;
      start_pc = s;
      end_pc   = e;
      loop_en  = l;
      tick();
      start    = 1'b0;
   endtask

   // Consume words until the unit returns to idle, checking hold-while-stalled.
   task automatic collect(input int max_cyc, input bit rnd);
      bit            held_v = 1'b0;
      bit            finished = 1'b0;
      logic [IW-1:0] held_d = '0;
      got_q.delete();
      gotpc_q.delete();
      done_cnt  = 0;
      first_cyc = -1;
      last_cyc  = -1;
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         if (done) done_cnt++;
         if (held_v) begin
            check("hold_valid", instf_m_valid, 1);
            check("hold_data", instf_m_data, held_d);
         end
         if (!busy && !instf_m_valid) begin
            finished = 1'b1;
            break;
         end
         instf_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (instf_m_valid && instf_m_ready) begin
            got_q.push_back(instf_m_data);
`ifdef INST_FETCH_PC_TAG_EN
            gotpc_q.push_back(instf_m_pc);
`endif
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         held_v = instf_m_valid && !instf_m_ready;
         held_d = instf_m_data;
         tick();
      end
      instf_m_ready = 1'b1;
      check("run_finished", finished, 1);
   endtask

   task automatic compare_seq(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      end
`ifdef INST_FETCH_PC_TAG_EN
      for (int i = 0; i < exppc_q.size(); i++) begin
         if (i < gotpc_q.size()) check($sformatf("%s_pc%0d", tag, i), gotpc_q[i], exppc_q[i]);
      end
`endif
   endtask

   task automatic expect_range(input logic [AW-1:0] s, input int n);
      logic [AW-1:0] a;
      exp_q.delete();
      exppc_q.delete();
      a = s;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(32'h1000 + 32'(a));
         exppc_q.push_back(a);
         a = a + AW'(1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", instf_m_valid, 0);
      check("rst_data", instf_m_data, 0);
`ifdef INST_FETCH_PC_TAG_EN
      check("rst_pc", instf_m_pc, 0);
`endif
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) ram_write(AW'(i), 32'h1000 + 32'(i));

      // Basic run, constant ready, latency and throughput
      instf_m_ready = 1'b1;
      start_run(0, 7, 1'b0);
      check("t1_busy", busy, 1);
      check("lat_t1_valid", instf_m_valid, 0);
      tick();
      check("lat_t2_valid", instf_m_valid, 0);
      tick();
      check("lat_t3_valid", instf_m_valid, 1);
      check("lat_t3_data", instf_m_data, 32'h1000);
      collect(40, 1'b0);
      expect_range(0, 8);
      compare_seq("t1");
      check("t1_done_cnt", done_cnt, 1);
      check("t1_span", last_cyc - first_cyc, 7);
      check("t1_idle", busy, 0);
      tick();
      check("t1_done_single", done, 0);

      // Random backpressure
      start_run(0, 7, 1'b0);
      collect(300, 1'b1);
      compare_seq("t2");
      check("t2_done_cnt", done_cnt, 1);

      // Address wrap through the top of the RAM
      ram_write(AW'(2046), 32'hC000_07FE);
      ram_write(AW'(2047), 32'hC000_07FF);
      start_run(AW'(2046), AW'(1), 1'b0);
      collect(40, 1'b0);
      exp_q   = {32'hC000_07FE, 32'hC000_07FF, 32'h1000, 32'h1001};
      exppc_q = {AW'(2046), AW'(2047), AW'(0), AW'(1)};
      compare_seq("t3");
      check("t3_done_cnt", done_cnt, 1);

      // Loop mode then abort
      start_run(4, 5, 1'b1);
      got_q.delete();
      ntx      = 0;
      done_cnt = 0;
      for (int c = 0; c < 40 && ntx < 7; c++) begin
         if (done) done_cnt++;
         if (instf_m_valid) begin
            got_q.push_back(instf_m_data);
            ntx++;
         end
         tick();
      end
      instf_m_ready = 1'b0;
      abort         = 1'b1;
      check("t4_busy_pre", busy, 1);
      tick();
      abort = 1'b0;
      check("t4_valid_post", instf_m_valid, 0);
      check("t4_busy_post", busy, 0);
      check("t4_done_post", done, 0);
      tick();
      check("t4_done_late", done, 0);
      check("t4_tx", ntx, 7);
      check("t4_done_cnt", done_cnt, 0);
      exp_q = {32'h1004, 32'h1005, 32'h1004, 32'h1005, 32'h1004, 32'h1005, 32'h1004};
      exppc_q.delete();
      compare_seq("t4");
      instf_m_ready = 1'b1;

      // Write and second start during a run are both ignored
      start_run(0, 7, 1'b0);
      instw_wen  = 1'b1;
      instw_addr = AW'(3);
      instw_data = 32'hDEAD;
      start      = 1'b1;
      start_pc   = AW'(4);
      end_pc     = AW'(5);
      loop_en    = 1'b1;
      tick();
      instw_wen = 1'b0;
      start     = 1'b0;
      collect(40, 1'b0);
      expect_range(0, 8);
      compare_seq("t5");
      check("t5_done_cnt", done_cnt, 1);
      start_run(3, 3, 1'b0);
      collect(40, 1'b0);
      expect_range(3, 1);
      compare_seq("t5b");

      // Asynchronous reset with the FIFO full
      instf_m_ready = 1'b0;
      start_run(0, 7, 1'b0);
      repeat (8) tick();
      check("t6_full_valid", instf_m_valid, 1);
      check("t6_full_data", instf_m_data, 32'h1000);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", busy, 0);
      check("t6_rst_valid", instf_m_valid, 0);
      check("t6_rst_data", instf_m_data, 0);
      check("t6_rst_done", done, 0);
`ifdef INST_FETCH_PC_TAG_EN
      check("t6_rst_pc", instf_m_pc, 0);
`endif
      #2;
      rst_n = 1'b1;
      tick();
      instf_m_ready = 1'b1;
      check("t6_idle", busy, 0);
      start_run(0, 3, 1'b0);
      collect(40, 1'b0);
      expect_range(0, 4);
      compare_seq("t6");
      check("t6_done_cnt", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
